// File: rtl/NetworkPkg.sv
// Shared handshake packet identifiers and scheduler state encoding.
package NetworkPkg;

  localparam logic PID_ACK = 1'b1;
  localparam logic PID_END = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } hnd_sched_state_t;

  // Bits needed to hold max_val, never narrower than min_width.
  function automatic int cnt_width(input int max_val, input int min_width);
    int w;
    w = $clog2(max_val + 1);
    return (w < min_width) ? min_width : w;
  endfunction

endpackage

// File: rtl/handshake_scheduler_counter.sv
// Free-running up counter with synchronous clear and enable.
module handshake_scheduler_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/handshake_scheduler.sv
// Schedules ACK and game-end handshake packets onto a single serializer,
// enforcing an idle gap between packets and aborting stalled transmissions.
module handshake_scheduler
  import NetworkPkg::*;
#(
  parameter int GAP_CYCLES  = 16,
  parameter int END_REPEATS = 3,
  parameter int TX_TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_active,
  input  logic       req_ack,
  input  logic       req_seqNum,
  input  logic       req_end,
  input  logic       tx_ready,
  input  logic       tx_done,
  output logic       tx_start,
  output logic       tx_pid,
  output logic       tx_seqNum,
  output logic       busy,
  output logic [3:0] ack_sent_cnt,
  output logic       tx_timeout_err
);

  localparam int GW = cnt_width(GAP_CYCLES, 1);
  localparam int TW = cnt_width(TX_TIMEOUT, 1);
  localparam int EW = cnt_width(END_REPEATS, 2);

  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TX_TIMEOUT - 1);
  localparam logic [EW-1:0] END_LOAD = EW'(END_REPEATS);

  hnd_sched_state_t state, state_next;

  logic          pending_ack;
  logic          ack_seq;
  logic [EW-1:0] end_left;
  logic          pending_end;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] to_cnt;

  logic eff_end;
  logic eff_ack;
  logic launch;
  logic launch_end;
  logic timeout;
  logic gap_done;
  logic to_en;
  logic to_clr;

  // Handshake: a packet is launched only when the serializer reports
  // tx_ready; tx_start pulses for one cycle and the packet is complete on
  // the tx_done pulse (or abandoned after TX_TIMEOUT SEND cycles).
  assign pending_end = (end_left != '0);
  assign eff_end     = pending_end | req_end;
  assign eff_ack     = pending_ack | req_ack;
  assign launch      = (state == IDLE) && game_active && (eff_end || eff_ack) && tx_ready;
  assign launch_end  = launch && eff_end;
  assign timeout     = (state == SEND) && !tx_done && (to_cnt == TO_LAST);
  assign gap_done    = (gap_cnt == GAP_LAST);
  assign to_en       = (state == SEND) && game_active;
  assign to_clr      = !to_en;

  handshake_scheduler_counter #(
    .WIDTH (TW)
  ) u_timeout_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (to_clr),
    .en    (to_en),
    .count (to_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (!game_active) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (launch) state_next = SEND;
        SEND:    if (tx_done || timeout) state_next = GAP;
        GAP:     if (gap_done) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_start       <= 1'b0;
      tx_pid         <= PID_ACK;
      tx_seqNum      <= 1'b0;
      busy           <= 1'b0;
      ack_sent_cnt   <= '0;
      tx_timeout_err <= 1'b0;
      pending_ack    <= 1'b0;
      ack_seq        <= 1'b0;
      end_left       <= '0;
      gap_cnt        <= '0;
    end else begin
      busy     <= (state_next != IDLE);
      tx_start <= launch;

      // Packet fields are frozen at launch so they stay stable through SEND.
      if (launch) begin
        tx_pid    <= launch_end ? PID_END : PID_ACK;
        tx_seqNum <= launch_end ? 1'b0 : (req_ack ? req_seqNum : ack_seq);
      end

      if (!game_active || state != GAP) begin
        gap_cnt <= '0;
      end else begin
        gap_cnt <= gap_cnt + GW'(1);
      end

      // A new request always wins over the consume on the tx_start cycle.
      if (!game_active) begin
        pending_ack <= 1'b0;
        ack_seq     <= 1'b0;
      end else if (req_ack) begin
        pending_ack <= 1'b1;
        ack_seq     <= req_seqNum;
      end else if (tx_start && tx_pid == PID_ACK) begin
        pending_ack <= 1'b0;
      end else if (timeout && tx_pid == PID_ACK) begin
        pending_ack <= 1'b1;
      end

      if (!game_active) begin
        end_left <= '0;
      end else if (req_end) begin
        end_left <= END_LOAD;
      end else if (tx_start && tx_pid == PID_END && pending_end) begin
        end_left <= end_left - EW'(1);
      end else if (timeout && tx_pid == PID_END && end_left != END_LOAD) begin
        end_left <= end_left + EW'(1);
      end

      if (!game_active) begin
        ack_sent_cnt <= '0;
      end else if (tx_start && tx_pid == PID_ACK) begin
        ack_sent_cnt <= ack_sent_cnt + 4'd1;
      end

      if (!game_active) begin
        tx_timeout_err <= 1'b0;
      end else if (timeout) begin
        tx_timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/handshake_scheduler.md
HANDSHAKE_SCHEDULER -- requirements
Module: handshake_scheduler

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 16: idle cycles enforced between handshake transmissions.
REQ-002 SHALL have parameter END_REPEATS, default 3: number of times each game-end packet is sent.
REQ-003 SHALL have parameter TX_TIMEOUT, default 255: maximum cycles in SEND before the transmission is aborted.
REQ-004 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port game_active  in  1  scheduler works only while high.
REQ-007 SHALL have port req_ack  in  1  1-cycle pulse requesting an ACK.
REQ-008 SHALL have port req_seqNum  in  1  seqNum to carry with the ACK, sampled with req_ack.
REQ-009 SHALL have port req_end  in  1  1-cycle pulse requesting game-end (local top-out).
REQ-010 SHALL have port tx_ready  in  1  handshake serializer idle.
REQ-011 SHALL have port tx_done  in  1  1-cycle pulse: serializer finished the packet.
REQ-012 SHALL have port tx_start  out  1  1-cycle pulse launching the serializer.
REQ-013 SHALL have port tx_pid  out  1  PID_ACK=1, PID_END=0; stable from tx_start until leaving SEND.
REQ-014 SHALL have port tx_seqNum  out  1  seqNum for the packet; stable as tx_pid.
REQ-015 SHALL have port busy  out  1  high in every state except IDLE.
REQ-016 SHALL have port ack_sent_cnt  out  4  count of ACKs launched, wraps 15->0.
REQ-017 SHALL have port tx_timeout_err  out  1  sticky flag: a SEND timed out.

Function
REQ-018 SHALL implement FSM states IDLE, SEND, GAP.
REQ-019 SHALL hold pending_ack: set by req_ack, which also latches req_seqNum into ack_seq. Further req_ack while pending SHALL coalesce into a single ACK carrying the newest seqNum.
REQ-020 SHALL hold end_left (2+ bits): req_end loads END_REPEATS, including any reload while nonzero. pending_end = (end_left != 0).
REQ-021 IDLE: when (pending_end | pending_ack) & tx_ready, SHALL go to SEND on the next edge with tx_start=1 for exactly that first SEND cycle.
REQ-022 Priority SHALL be END over ACK, including when both request on the same cycle.
REQ-023 On the tx_start cycle, SHALL latch tx_pid/tx_seqNum and then update by type:
- ACK launched: clear pending_ack and increment ack_sent_cnt.
- END launched: decrement end_left.
A request arriving on that same cycle SHALL set the pending bit again, with set winning over clear.
REQ-024 SEND: on tx_done, SHALL go to GAP.
REQ-025 SEND timeout: after TX_TIMEOUT cycles without tx_done, SHALL set tx_timeout_err, re-arm the aborted request (pending_ack=1 or end_left+1, saturating at END_REPEATS), and go to GAP.
REQ-026 GAP SHALL last exactly GAP_CYCLES cycles (counter width clog2(GAP_CYCLES+1)), then go to IDLE. Requests in SEND or GAP SHALL be recorded and never lost.
REQ-027 tx_start SHALL be at least 1+GAP_CYCLES+(SEND length) cycles apart, and SHALL never assert while tx_ready=0.
REQ-028 While game_active=0:
- Go to IDLE from any state.
- Clear pending_ack, ack_seq, end_left, and the gap/timeout counters.
- Hold tx_start=0 and ignore requests.
ack_sent_cnt and tx_timeout_err SHALL also clear.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 On rst high at a rising edge, SHALL set: state=IDLE, tx_start=0, tx_pid=PID_ACK, tx_seqNum=0, busy=0, ack_sent_cnt=0, tx_timeout_err=0, all pending/counters=0.
REQ-031 Reset mid-SEND or mid-GAP SHALL abort with no further tx_start, and SHALL take priority over all other inputs.

Structure
REQ-032 PID_ACK/PID_END constants and the hnd_sched_state_t enum SHALL live in NetworkPkg.
REQ-033 SHALL reuse the existing counter sub-module for the SEND timeout counter; the GAP counter SHALL be inline.

Verification
REQ-034 req_ack(seq=1) in IDLE, tx_ready=1 -> tx_start 1 cycle later, tx_pid=1, tx_seqNum=1, ack_sent_cnt=1.
REQ-035 req_ack and req_end on the same cycle -> 3 END packets (pid=0) then 1 ACK, each separated by >=16 GAP cycles.
REQ-036 req_ack(seq=0), req_ack(seq=1), req_ack(seq=0) during SEND/GAP -> exactly one further ACK, with tx_seqNum=0.
REQ-037 No tx_done for 255 cycles -> tx_timeout_err=1, GAP, then the same ACK is resent.
REQ-038 game_active drops mid-SEND with END pending -> IDLE next cycle, no tx_start, counters=0.
REQ-039 rst asserted in GAP -> all outputs at reset values on the following cycle.
